// File: rtl/nn_pkg.sv
// nn_pkg: shared sequencer state encoding, default word width and index-width helper
package nn_pkg;
    localparam int DEFAULT_DATA_WIDTH = 16;
    typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} seq_state_t;
    function automatic int idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/out_capture_buf.sv
// out_capture_buf: per-neuron result registers latched by valid pulse, with all-full flag and indexed read
module out_capture_buf import nn_pkg::*; #(
    parameter int NUM_NEURON = 10,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IW = idx_width(NUM_NEURON)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             clr,
    input  logic [NUM_NEURON-1:0]            pulse,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0] data,
    input  logic [IW-1:0]                    rd_idx,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             full
);
    // sized to the full index range so any rd_idx is a legal read; spare entries stay zero
    logic [DATA_WIDTH-1:0] caps [2**IW];
    logic [NUM_NEURON-1:0] flags;
    assign full = &flags;
    assign rd_data = caps[rd_idx];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            caps <= '{default: '0};
            flags <= '0;
        end else begin
            flags <= clr ? '0 : en ? flags | pulse : flags;
            for (int k = 0; k < NUM_NEURON; k++)
                if (en && pulse[k]) caps[k] <= data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: broadcasts one inference to a neuron layer, gathers per-neuron results and serializes them
module layer_sequencer import nn_pkg::*; #(
    parameter int NUM_NEURON = 10,
    parameter int NUM_INPUT  = 784,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            nrn_in,
    output logic                             nrn_in_valid,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0] nrn_out,
    input  logic [NUM_NEURON-1:0]            nrn_out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             err
);
    localparam int CW = $clog2(NUM_INPUT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = idx_width(NUM_NEURON);
    seq_state_t            state;
    logic [CW-1:0]         in_cnt;
    logic [TW-1:0]         wait_cnt;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  accept;
    logic                  timeout;
    logic                  last_out;
    // the read port looks one word ahead so out_data can be registered on each transfer
    always_comb begin
        accept   = in_valid && in_ready;
        timeout  = wait_cnt == TW'(TIMEOUT - 1);
        last_out = idx == IW'(NUM_NEURON - 1);
        rd_idx   = state == DRAIN ? idx + 1'b1 : '0;
    end
    out_capture_buf #(.NUM_NEURON(NUM_NEURON), .DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .en      (state == FEED || state == WAIT),
        .clr     (state == WAIT && (full || timeout)),
        .pulse   (nrn_out_valid),
        .data    (nrn_out),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .full    (full)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            in_cnt <= '0;
            wait_cnt <= '0;
            idx <= '0;
            in_ready <= 1'b0;
            nrn_in <= '0;
            nrn_in_valid <= 1'b0;
            out_data <= '0;
            out_valid <= 1'b0;
            busy <= 1'b0;
            err <= 1'b0;
        end else begin
            nrn_in_valid <= accept;
            case (state)
                IDLE: begin
                    state <= FEED;
                    in_ready <= 1'b1;
                    busy <= 1'b1;
                    in_cnt <= '0;
                    wait_cnt <= '0;
                    idx <= '0;
                end
                FEED: if (accept) begin
                    nrn_in <= in_data;
                    in_cnt <= in_cnt + 1'b1;
                    if (in_cnt == '0) err <= 1'b0;
                    if (in_cnt == CW'(NUM_INPUT - 1)) begin
                        in_ready <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (full) begin
                        state <= DRAIN;
                        out_valid <= 1'b1;
                        out_data <= rd_data;
                    end else if (timeout) begin
                        state <= IDLE;
                        busy <= 1'b0;
                        err <= 1'b1;
                    end
                end
                DRAIN: if (out_ready) begin
                    idx <= idx + 1'b1;
                    out_data <= last_out ? '0 : rd_data;
                    if (last_out) begin
                        out_valid <= 1'b0;
                        state <= IDLE;
                        busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_NEURON, default 10: neurons in the sequenced layer.
REQ-002 SHALL have parameter NUM_INPUT, default 784: input words per inference, equal to each neuron's weight count.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: input and output word width, signed fixed-point.
REQ-004 SHALL have parameter TIMEOUT, default 64: maximum cycles in WAIT before error.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1: clock, all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-008 SHALL have port in_data, input, DATA_WIDTH: upstream activation word.
REQ-009 SHALL have port in_valid, input, 1: in_data valid.
REQ-010 SHALL have port in_ready, output, 1: sequencer accepts in_data; high only in FEED.
REQ-011 SHALL have port nrn_in, output, DATA_WIDTH: word broadcast to all neurons.
REQ-012 SHALL have port nrn_in_valid, output, 1: broadcast word valid, one pulse per word.
REQ-013 SHALL have port nrn_out, input, NUM_NEURON*DATA_WIDTH: neuron outputs, neuron k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port nrn_out_valid, input, NUM_NEURON: per-neuron single-cycle output-valid pulse.
REQ-015 SHALL have port out_data, output, DATA_WIDTH: serialized layer result.
REQ-016 SHALL have port out_valid, output, 1: out_data valid.
REQ-017 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-018 SHALL have port busy, output, 1: state is not IDLE.
REQ-019 SHALL have port err, output, 1: sticky timeout flag, cleared only by rst or the next accepted first input.

Function
REQ-020 SHALL implement FSM states IDLE, FEED, WAIT, DRAIN.
REQ-021 IDLE SHALL go to FEED on the next cycle; err is cleared when the first input word is accepted in FEED.
REQ-022 In FEED, an input word is accepted in each cycle with in_valid&in_ready; gaps in in_valid are allowed.
REQ-023 Each accepted word SHALL appear on nrn_in with nrn_in_valid high exactly 1 cycle later (registered); nrn_in_valid is otherwise 0.
REQ-024 An input counter (width clog2(NUM_INPUT+1)) SHALL count accepted words; on the NUM_INPUT-th acceptance, in_ready drops the next cycle and the state goes to WAIT.
REQ-025 In WAIT, each nrn_out_valid[k] pulse SHALL latch nrn_out slice k into capture register k and set sticky flag k; pulses arriving during FEED SHALL also be latched.
REQ-026 When all NUM_NEURON flags are set, the state SHALL go to DRAIN the next cycle and clear all flags.
REQ-027 A WAIT cycle counter SHALL increment every WAIT cycle; on reaching TIMEOUT with flags incomplete, it SHALL set err, clear the flags, and return to IDLE with no output emitted.
REQ-028 In DRAIN, out_data SHALL equal capture register idx with out_valid high; idx starts at 0 and advances on out_valid&out_ready.
REQ-029 out_data and out_valid SHALL hold stable while out_ready is low.
REQ-030 On the transfer of idx=NUM_NEURON-1, out_valid SHALL drop the next cycle and the state SHALL go to IDLE.
REQ-031 nrn_out_valid pulses outside FEED/WAIT SHALL be ignored.
REQ-032 No arithmetic SHALL be applied to data; words pass bit-exact.

Reset
REQ-033 rst SHALL asynchronously force IDLE; in_ready, nrn_in_valid, out_valid, busy, err=0; nrn_in and out_data=0; all counters, flags, and capture registers=0.
REQ-034 rst asserted mid-FEED/WAIT/DRAIN SHALL abandon the inference; after release, the sequence restarts from IDLE with no residual output.

Structure
REQ-035 State encoding (IDLE/FEED/WAIT/DRAIN enum) and the default DATA_WIDTH SHALL live in the shared package nn_pkg.
REQ-036 Capture registers and flags SHALL be one sub-module, out_capture_buf (latch-by-pulse, all-full flag, indexed read), instantiated once.

Verification
REQ-037 NUM_INPUT=4, NUM_NEURON=3: feed 1,2,3,4 back-to-back -> nrn_in_valid pulses 4 cycles, each 1 cycle after acceptance; in_ready low after the 4th word.
REQ-038 Neurons pulse valid out of order (2, 0, 1) with values 0x0030, 0x0010, 0x0020 -> DRAIN emits 0x0010, 0x0020, 0x0030 in order.
REQ-039 out_ready held low 5 cycles during DRAIN -> out_data stable at index 0 value, out_valid stays high, no skip.
REQ-040 Only 2 of 3 neurons pulse, TIMEOUT=8 -> err=1 after 8 WAIT cycles, IDLE, out_valid never asserted; the next first input accepted clears err.
REQ-041 rst pulsed mid-FEED after 2 words -> all outputs 0 immediately (asynchronously); the next inference needs a full 4 words.
REQ-042 in_valid toggling 1,0,1,0 -> exactly 4 acceptances counted, nrn_in_valid pulses match.
